priority_dispatch: RTL

Sequential request dispatcher that feeds a fixed-priority one-hot select. Single-cycle request pulses on up to DW lines are latched into a sticky pending vector. The highest-index pending request is issued as a registered one-hot grant plus binary index over a valid/ready handshake. Each request is served exactly once. It sits between bursty request sources and a single shared resource, such as an interrupt or DMA channel.

---
 rtl/priority_dispatch_pkg.sv | 12 +
 rtl/priority_dispatch_onehot_to_idx.sv | 22 ++
 rtl/priority_dispatch.sv | 107 ++++++++++
 3 files changed

// File: rtl/priority_dispatch_pkg.sv
// Shared types for the priority dispatcher: control state encoding and default width.
package priority_dispatch_pkg;

   localparam int unsigned DW_DEFAULT = 32;

   // Single state bit: HOLD means the grant register carries a live grant.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage : priority_dispatch_pkg

// File: rtl/priority_dispatch_onehot_to_idx.sv
// Combinational one-hot to binary encoder; each index bit is the OR of the one-hot
// bits whose position has that bit set. Output is zero for an all-zero input.
module onehot_to_idx #(
   parameter int unsigned DW   = 32,
   parameter int unsigned IDXW = (DW > 1) ? $clog2(DW) : 1
) (
   input  logic [DW-1:0]   onehot,
   output logic [IDXW-1:0] idx
);

   always_comb begin
      idx = '0;
      for (int unsigned b = 0; b < IDXW; b++) begin
         for (int unsigned i = 0; i < DW; i++) begin
            if (((i >> b) & 32'd1) == 32'd1) begin
               idx[b] = idx[b] | onehot[i];
            end
         end
      end
   end

endmodule : onehot_to_idx

// File: rtl/priority_dispatch.sv
// Sticky-pending request dispatcher: highest-index pending line is issued as a
// registered one-hot grant plus binary index over a valid/ready handshake.
module priority_dispatch
   import priority_dispatch_pkg::*;
#(
   parameter  int unsigned DW   = DW_DEFAULT,
   localparam int unsigned IDXW = $clog2(DW)
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [DW-1:0]   req_in,
   output logic [DW-1:0]   grant_out,
   output logic [IDXW-1:0] grant_idx,
   output logic            grant_valid,
   input  logic            grant_ready,
   output logic [DW-1:0]   pending,
   output logic            busy
);

   state_e          state_q;
   state_e          state_d;
   logic [DW-1:0]   sel;
   logic [IDXW-1:0] sel_idx;
   logic            found;
   logic            load;
   logic [DW-1:0]   load_mask;
   logic [DW-1:0]   pending_d;
   logic [DW-1:0]   grant_d;
   logic [IDXW-1:0] idx_d;

   // MSB-priority select on the registered pending vector only.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = int'(DW) - 1; i >= 0; i--) begin
         if (!found && pending[i]) begin
            sel[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   onehot_to_idx #(
      .DW   (DW),
      .IDXW (IDXW)
   ) u_enc (
      .onehot (sel),
      .idx    (sel_idx)
   );

   // Control: load whenever the grant slot is free or being accepted and work exists.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pending) begin
               load    = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (grant_ready) begin
               if (|pending) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A request for the line being loaded this edge re-pends it rather than being lost.
   always_comb begin
      load_mask = load ? sel : '0;
      pending_d = (pending & ~load_mask) | req_in;
      grant_d   = grant_out;
      idx_d     = grant_idx;
      if (load) begin
         grant_d = sel;
         idx_d   = sel_idx;
      end else if (state_d == ST_IDLE) begin
         grant_d = '0;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= ST_IDLE;
         pending   <= '0;
         grant_out <= '0;
         grant_idx <= '0;
      end else begin
         state_q   <= state_d;
         pending   <= pending_d;
         grant_out <= grant_d;
         grant_idx <= idx_d;
      end
   end

   assign grant_valid = (state_q == ST_HOLD);
   assign busy        = grant_valid | (|pending);

endmodule : priority_dispatch
